// File: rtl/ball_motion_pkg.sv
// Shared types, table bounds and velocity helpers for the per-ball kinematics stage.
package ball_motion_pkg;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        ROLLING = 2'd1,
        SUNK    = 2'd2
    } ball_state_t;

    localparam int POS_W     = 17;
    localparam int VEL_W     = 11;
    localparam int FRAC_BITS = 6;
    localparam int MIN_X     = 0;
    localparam int MAX_X     = 607;
    localparam int MIN_Y     = 0;
    localparam int MAX_Y     = 447;

    localparam logic signed [VEL_W-1:0] VEL_MAX = 11'sd1023;

    typedef struct packed {
        logic signed [POS_W-1:0] pos;
        logic signed [VEL_W-1:0] vel;
    } axis_t;

    // The one unrepresentable-after-negation value, -1024, is pulled in to -1023.
    function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [VEL_W-1:0] v);
        return (v < -VEL_MAX) ? -VEL_MAX : v;
    endfunction

    function automatic axis_t integrate_axis(
        input logic signed [POS_W-1:0] pos,
        input logic signed [VEL_W-1:0] vel,
        input logic signed [POS_W-1:0] lo,
        input logic signed [POS_W-1:0] hi
    );
        axis_t                   res;
        logic signed [POS_W-1:0] sum;
        sum     = pos + {{(POS_W-VEL_W){vel[VEL_W-1]}}, vel};
        res.pos = sum;
        res.vel = vel;
        if (sum < lo) begin
            res.pos = lo;
            res.vel = -vel;
        end else if (sum > hi) begin
            res.pos = hi;
            res.vel = -vel;
        end
        return res;
    endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Signal bundle between hit_controller/cue logic and one ball_motion instance.
interface ball_motion_if;
    import ball_motion_pkg::*;

    logic                    startOfFrame;
    logic                    collisionOccurred;
    logic signed [VEL_W-1:0] velXIn;
    logic signed [VEL_W-1:0] velYIn;
    logic                    holeHit;
    logic [2:0]              holeNum;
    logic                    shotValid;
    logic signed [VEL_W-1:0] shotVelX;
    logic signed [VEL_W-1:0] shotVelY;
    logic                    respawn;
    logic signed [VEL_W-1:0] topLeftX;
    logic signed [VEL_W-1:0] topLeftY;
    logic signed [VEL_W-1:0] velX;
    logic signed [VEL_W-1:0] velY;
    logic                    ballVisible;
    logic                    ballMoving;
    logic [2:0]              sunkHoleNum;

    modport master (
        output startOfFrame, collisionOccurred, velXIn, velYIn, holeHit, holeNum,
               shotValid, shotVelX, shotVelY, respawn,
        input  topLeftX, topLeftY, velX, velY, ballVisible, ballMoving, sunkHoleNum
    );

    modport slave (
        input  startOfFrame, collisionOccurred, velXIn, velYIn, holeHit, holeNum,
               shotValid, shotVelX, shotVelY, respawn,
        output topLeftX, topLeftY, velX, velY, ballVisible, ballMoving, sunkHoleNum
    );
endinterface

// File: rtl/ball_motion_friction_decay.sv
// One velocity axis moved i_step toward zero when enabled; never crosses zero.
module ball_motion_friction_decay
    import ball_motion_pkg::*;
(
    input  logic signed [VEL_W-1:0] i_vel,
    input  logic signed [VEL_W-1:0] i_step,
    input  logic                    i_en,
    output logic signed [VEL_W-1:0] o_vel
);
    always_comb begin
        o_vel = i_vel;
        if (i_en) begin
            if (i_vel > i_step)
                o_vel = i_vel - i_step;
            else if (i_vel < -i_step)
                o_vel = i_vel + i_step;
            else
                o_vel = '0;
        end
    end
endmodule

// File: rtl/ball_motion.sv
// Per-ball kinematics: latches hit/shot events between frames, integrates and applies friction per frame.
//   state   | meaning
//   READY   | at rest, accepts a cue shot
//   ROLLING | moving; integrates, decays, honours collision overrides
//   SUNK    | in a hole, invisible until respawn
module ball_motion
    import ball_motion_pkg::*;
#(
    parameter int INIT_X        = 100,
    parameter int INIT_Y        = 200,
    parameter int FRICTION_DIV  = 4,
    parameter int FRICTION_STEP = 1
) (
    input  logic         clk,
    input  logic         resetN,
    ball_motion_if.slave bus
);
    localparam int CNT_W = (FRICTION_DIV > 1) ? $clog2(FRICTION_DIV) : 1;
    localparam logic signed [POS_W-1:0] INIT_PX = POS_W'(INIT_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] INIT_PY = POS_W'(INIT_Y << FRAC_BITS);
    localparam logic signed [POS_W-1:0] LO_X    = POS_W'(MIN_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] HI_X    = POS_W'(MAX_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] LO_Y    = POS_W'(MIN_Y << FRAC_BITS);
    localparam logic signed [POS_W-1:0] HI_Y    = POS_W'(MAX_Y << FRAC_BITS);
    localparam logic signed [VEL_W-1:0] STEP_V  = VEL_W'(FRICTION_STEP);

    ball_state_t             r_state, w_state_nx;
    logic signed [POS_W-1:0] r_pos_x, r_pos_y, w_pos_x_nx, w_pos_y_nx;
    logic signed [VEL_W-1:0] r_vel_x, r_vel_y, w_vel_x_nx, w_vel_y_nx;
    logic [CNT_W-1:0]        r_fric_cnt, w_cnt_nx;
    logic [2:0]              r_sunk_num, w_sunk_nx;
    logic                    r_col_pend, r_hole_pend, r_shot_pend, r_resp_pend;
    logic signed [VEL_W-1:0] r_col_vx, r_col_vy, r_shot_vx, r_shot_vy;
    logic [2:0]              r_hole_num;

    logic signed [VEL_W-1:0] w_base_vx, w_base_vy, w_fric_vx, w_fric_vy;
    axis_t                   w_int_x, w_int_y;
    logic                    w_fric_tc;

    // READY only integrates on a shot; ROLLING uses a pending override if there is one.
    assign w_base_vx = (r_state == READY) ? r_shot_vx : (r_col_pend ? r_col_vx : r_vel_x);
    assign w_base_vy = (r_state == READY) ? r_shot_vy : (r_col_pend ? r_col_vy : r_vel_y);
    assign w_int_x   = integrate_axis(r_pos_x, w_base_vx, LO_X, HI_X);
    assign w_int_y   = integrate_axis(r_pos_y, w_base_vy, LO_Y, HI_Y);
    assign w_fric_tc = (r_fric_cnt == CNT_W'(FRICTION_DIV - 1));

    ball_motion_friction_decay u_fric_x (
        .i_vel(w_int_x.vel), .i_step(STEP_V), .i_en(w_fric_tc), .o_vel(w_fric_vx)
    );
    ball_motion_friction_decay u_fric_y (
        .i_vel(w_int_y.vel), .i_step(STEP_V), .i_en(w_fric_tc), .o_vel(w_fric_vy)
    );

    always_comb begin
        w_state_nx = r_state;
        w_pos_x_nx = r_pos_x;
        w_pos_y_nx = r_pos_y;
        w_vel_x_nx = r_vel_x;
        w_vel_y_nx = r_vel_y;
        w_cnt_nx   = r_fric_cnt;
        w_sunk_nx  = r_sunk_num;
        if (r_resp_pend || bus.respawn) begin
            w_state_nx = READY;
            w_pos_x_nx = INIT_PX;
            w_pos_y_nx = INIT_PY;
            w_vel_x_nx = '0;
            w_vel_y_nx = '0;
            w_cnt_nx   = '0;
        end else if (r_state == SUNK) begin
            w_vel_x_nx = '0;
            w_vel_y_nx = '0;
        end else if (r_hole_pend) begin
            w_state_nx = SUNK;
            w_vel_x_nx = '0;
            w_vel_y_nx = '0;
            w_cnt_nx   = '0;
            w_sunk_nx  = r_hole_num;
        end else if ((r_state == ROLLING && r_col_pend) ||
                     (r_state == READY && r_shot_pend && (r_shot_vx != '0 || r_shot_vy != '0))) begin
            w_state_nx = ROLLING;
            w_pos_x_nx = w_int_x.pos;
            w_pos_y_nx = w_int_y.pos;
            w_vel_x_nx = w_int_x.vel;
            w_vel_y_nx = w_int_y.vel;
        end else if (r_state == ROLLING) begin
            w_pos_x_nx = w_int_x.pos;
            w_pos_y_nx = w_int_y.pos;
            w_vel_x_nx = w_fric_vx;
            w_vel_y_nx = w_fric_vy;
            w_cnt_nx   = w_fric_tc ? '0 : r_fric_cnt + 1'b1;
            if (w_fric_vx == '0 && w_fric_vy == '0) begin
                w_state_nx = READY;
                w_cnt_nx   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= READY;
            r_pos_x    <= INIT_PX;
            r_pos_y    <= INIT_PY;
            r_vel_x    <= '0;
            r_vel_y    <= '0;
            r_fric_cnt <= '0;
            r_sunk_num <= '0;
        end else if (bus.startOfFrame) begin
            r_state    <= w_state_nx;
            r_pos_x    <= w_pos_x_nx;
            r_pos_y    <= w_pos_y_nx;
            r_vel_x    <= w_vel_x_nx;
            r_vel_y    <= w_vel_y_nx;
            r_fric_cnt <= w_cnt_nx;
            r_sunk_num <= w_sunk_nx;
        end
    end

    // Event capture between frames; the frame pulse consumes and clears everything.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_col_pend  <= 1'b0;
            r_hole_pend <= 1'b0;
            r_shot_pend <= 1'b0;
            r_resp_pend <= 1'b0;
            r_col_vx    <= '0;
            r_col_vy    <= '0;
            r_shot_vx   <= '0;
            r_shot_vy   <= '0;
            r_hole_num  <= '0;
        end else if (bus.startOfFrame) begin
            r_col_pend  <= 1'b0;
            r_hole_pend <= 1'b0;
            r_shot_pend <= 1'b0;
            r_resp_pend <= 1'b0;
        end else begin
            if (bus.collisionOccurred && !r_col_pend) begin
                r_col_pend <= 1'b1;
                r_col_vx   <= sat_vel(bus.velXIn);
                r_col_vy   <= sat_vel(bus.velYIn);
            end
            if (bus.holeHit && !r_hole_pend) begin
                r_hole_pend <= 1'b1;
                r_hole_num  <= bus.holeNum;
            end
            if (bus.shotValid && r_state == READY) begin
                r_shot_pend <= 1'b1;
                r_shot_vx   <= sat_vel(bus.shotVelX);
                r_shot_vy   <= sat_vel(bus.shotVelY);
            end
            if (bus.respawn)
                r_resp_pend <= 1'b1;
        end
    end

    assign bus.topLeftX    = VEL_W'(r_pos_x >>> FRAC_BITS);
    assign bus.topLeftY    = VEL_W'(r_pos_y >>> FRAC_BITS);
    assign bus.velX        = r_vel_x;
    assign bus.velY        = r_vel_y;
    assign bus.ballVisible = (r_state != SUNK);
    assign bus.ballMoving  = (r_state == ROLLING);
    assign bus.sunkHoleNum = r_sunk_num;
endmodule
